// File: rtl/axi_id_remap_pkg.sv
// axi_id_remap_pkg: shared types for the AXI ID remapper.
//   mst_id_width() : narrow ID width for a given number of unique IDs
//   cnt_t          : outstanding-transaction counter of one table entry
//   entry_t        : remap table entry (stored wide id + outstanding count)
// The entry types are sized from the package defaults below; the top-level
// parameters default to the same values and must be kept consistent with them.
package axi_id_remap_pkg;

  localparam int unsigned SlvIdWidthDflt   = 4;
  localparam int unsigned MaxUniqIdsDflt   = 4;
  localparam int unsigned MaxTxnsPerIdDflt = 4;

  function automatic int unsigned mst_id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CntWidth = $clog2(MaxTxnsPerIdDflt + 1);

  typedef logic [CntWidth-1:0] cnt_t;

  typedef struct packed {
    logic [SlvIdWidthDflt-1:0] id;
    cnt_t                      cnt;
  } entry_t;

endpackage

// File: rtl/axi_id_remap_table.sv
// axi_id_remap_table: one remap table (write or read direction).
//   lookup_id_i  : wide id of the request currently presented
//   push_i       : request handshake this cycle (uses push_idx_o)
//   pop_i        : final response handshake this cycle (entry pop_idx_i)
//   accept_o     : request may be forwarded now
//   push_idx_o   : narrow id assigned to the request
//   pop_id_o     : stored wide id of entry pop_idx_i
//   pop_free_o   : entry pop_idx_i is free (only with AXI_ID_REMAP_ERR_EN)
// An entry is busy iff its count is non-zero; there is no other state.
module axi_id_remap_table
  import axi_id_remap_pkg::*;
#(
  parameter int unsigned SlvIdWidth   = SlvIdWidthDflt,
  parameter int unsigned MaxUniqIds   = MaxUniqIdsDflt,
  parameter int unsigned MaxTxnsPerId = MaxTxnsPerIdDflt,
  parameter int unsigned IdxWidth     = mst_id_width(MaxUniqIds)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [SlvIdWidth-1:0] lookup_id_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [IdxWidth-1:0]   pop_idx_i,
  output logic                  accept_o,
  output logic [IdxWidth-1:0]   push_idx_o,
  output logic [SlvIdWidth-1:0] pop_id_o
`ifdef AXI_ID_REMAP_ERR_EN
  ,
  output logic                  pop_free_o
`endif
);

  entry_t tbl_q [MaxUniqIds];

  logic                hit, any_free;
  logic [IdxWidth-1:0] hit_idx, free_idx;
  cnt_t                hit_cnt;
  logic                pop_free;
  logic [MaxUniqIds-1:0] inc, dec;

  // Descending scan so the lowest free index wins. Allocation looks only at
  // the registered counts, so an entry popping to zero this cycle is not
  // reused until the next one.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_cnt  = '0;
    any_free = 1'b0;
    free_idx = '0;
    pop_id_o = '0;
    pop_free = 1'b0;
    for (int i = MaxUniqIds - 1; i >= 0; i--) begin
      if (tbl_q[i].cnt == '0) begin
        any_free = 1'b1;
        free_idx = IdxWidth'(i);
      end else if (tbl_q[i].id == lookup_id_i) begin
        hit     = 1'b1;
        hit_idx = IdxWidth'(i);
        hit_cnt = tbl_q[i].cnt;
      end
      if (pop_idx_i == IdxWidth'(i)) begin
        pop_id_o = tbl_q[i].id;
        pop_free = (tbl_q[i].cnt == '0);
      end
    end
    accept_o   = hit ? (hit_cnt < cnt_t'(MaxTxnsPerId)) : any_free;
    push_idx_o = hit ? hit_idx : free_idx;
  end

`ifdef AXI_ID_REMAP_ERR_EN
  assign pop_free_o = pop_free;
`endif

  // A pop on a free entry never decrements, so the count cannot underflow.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < MaxUniqIds; i++) begin
      inc[i] = push_i && (push_idx_o == IdxWidth'(i));
      dec[i] = pop_i && (pop_idx_i == IdxWidth'(i)) && (tbl_q[i].cnt != '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MaxUniqIds; i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        if (inc[i]) tbl_q[i].id <= lookup_id_i;
        if (inc[i] && !dec[i])      tbl_q[i].cnt <= tbl_q[i].cnt + cnt_t'(1);
        else if (dec[i] && !inc[i]) tbl_q[i].cnt <= tbl_q[i].cnt - cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/axi_id_remap.sv
// axi_id_remap: compresses wide upstream AXI IDs into a narrow ID space.
//   slv_aw_* / slv_ar_*  : upstream requests (wide id + opaque payload)
//   mst_aw_* / mst_ar_*  : downstream requests (narrow id = table index)
//   mst_b_* / mst_r_*    : downstream responses (narrow id)
//   slv_b_* / slv_r_*    : upstream responses (wide id restored from table)
//   err_o                : sticky, response to a free entry (only when the
//                          macro AXI_ID_REMAP_ERR_EN is defined)
// Fully combinational forwarding; requests stall only on table pressure.
// All valid/ready outputs are held low while rst_i is high.
module axi_id_remap
  import axi_id_remap_pkg::*;
#(
  parameter int unsigned SlvIdWidth   = SlvIdWidthDflt,
  parameter int unsigned MaxUniqIds   = MaxUniqIdsDflt,
  parameter int unsigned MaxTxnsPerId = MaxTxnsPerIdDflt,
  parameter int unsigned AwPldWidth   = 64,
  parameter int unsigned ArPldWidth   = 64,
  parameter int unsigned BPldWidth    = 2,
  parameter int unsigned RPldWidth    = 35,
  parameter int unsigned MstIdWidth   = mst_id_width(MaxUniqIds)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [SlvIdWidth-1:0] slv_aw_id_i,
  input  logic [AwPldWidth-1:0] slv_aw_pld_i,
  input  logic                  slv_aw_valid_i,
  output logic                  slv_aw_ready_o,
  output logic [MstIdWidth-1:0] mst_aw_id_o,
  output logic [AwPldWidth-1:0] mst_aw_pld_o,
  output logic                  mst_aw_valid_o,
  input  logic                  mst_aw_ready_i,
  input  logic [MstIdWidth-1:0] mst_b_id_i,
  input  logic [BPldWidth-1:0]  mst_b_pld_i,
  input  logic                  mst_b_valid_i,
  output logic                  mst_b_ready_o,
  output logic [SlvIdWidth-1:0] slv_b_id_o,
  output logic [BPldWidth-1:0]  slv_b_pld_o,
  output logic                  slv_b_valid_o,
  input  logic                  slv_b_ready_i,
  input  logic [SlvIdWidth-1:0] slv_ar_id_i,
  input  logic [ArPldWidth-1:0] slv_ar_pld_i,
  input  logic                  slv_ar_valid_i,
  output logic                  slv_ar_ready_o,
  output logic [MstIdWidth-1:0] mst_ar_id_o,
  output logic [ArPldWidth-1:0] mst_ar_pld_o,
  output logic                  mst_ar_valid_o,
  input  logic                  mst_ar_ready_i,
  input  logic [MstIdWidth-1:0] mst_r_id_i,
  input  logic [RPldWidth-1:0]  mst_r_pld_i,
  input  logic                  mst_r_last_i,
  input  logic                  mst_r_valid_i,
  output logic                  mst_r_ready_o,
  output logic [SlvIdWidth-1:0] slv_r_id_o,
  output logic [RPldWidth-1:0]  slv_r_pld_o,
  output logic                  slv_r_last_o,
  output logic                  slv_r_valid_o,
  input  logic                  slv_r_ready_i
`ifdef AXI_ID_REMAP_ERR_EN
  ,
  output logic                  err_o
`endif
);

  logic aw_accept, ar_accept;
  logic aw_hs, ar_hs, b_hs, r_hs, r_last_hs;

  assign mst_aw_valid_o = slv_aw_valid_i & aw_accept & ~rst_i;
  assign slv_aw_ready_o = mst_aw_ready_i & aw_accept & ~rst_i;
  assign mst_aw_pld_o   = slv_aw_pld_i;
  assign aw_hs          = mst_aw_valid_o & mst_aw_ready_i;

  assign mst_ar_valid_o = slv_ar_valid_i & ar_accept & ~rst_i;
  assign slv_ar_ready_o = mst_ar_ready_i & ar_accept & ~rst_i;
  assign mst_ar_pld_o   = slv_ar_pld_i;
  assign ar_hs          = mst_ar_valid_o & mst_ar_ready_i;

  assign slv_b_valid_o  = mst_b_valid_i & ~rst_i;
  assign mst_b_ready_o  = slv_b_ready_i & ~rst_i;
  assign slv_b_pld_o    = mst_b_pld_i;
  assign b_hs           = slv_b_valid_o & slv_b_ready_i;

  assign slv_r_valid_o  = mst_r_valid_i & ~rst_i;
  assign mst_r_ready_o  = slv_r_ready_i & ~rst_i;
  assign slv_r_pld_o    = mst_r_pld_i;
  assign slv_r_last_o   = mst_r_last_i;
  assign r_hs           = slv_r_valid_o & slv_r_ready_i;
  assign r_last_hs      = r_hs & mst_r_last_i;

`ifdef AXI_ID_REMAP_ERR_EN
  logic b_pop_free, r_pop_free;
`endif

  axi_id_remap_table #(
    .SlvIdWidth  (SlvIdWidth),
    .MaxUniqIds  (MaxUniqIds),
    .MaxTxnsPerId(MaxTxnsPerId),
    .IdxWidth    (MstIdWidth)
  ) i_wr_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .lookup_id_i(slv_aw_id_i),
    .push_i     (aw_hs),
    .pop_i      (b_hs),
    .pop_idx_i  (mst_b_id_i),
    .accept_o   (aw_accept),
    .push_idx_o (mst_aw_id_o),
    .pop_id_o   (slv_b_id_o)
`ifdef AXI_ID_REMAP_ERR_EN
    ,
    .pop_free_o (b_pop_free)
`endif
  );

  axi_id_remap_table #(
    .SlvIdWidth  (SlvIdWidth),
    .MaxUniqIds  (MaxUniqIds),
    .MaxTxnsPerId(MaxTxnsPerId),
    .IdxWidth    (MstIdWidth)
  ) i_rd_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .lookup_id_i(slv_ar_id_i),
    .push_i     (ar_hs),
    .pop_i      (r_last_hs),
    .pop_idx_i  (mst_r_id_i),
    .accept_o   (ar_accept),
    .push_idx_o (mst_ar_id_o),
    .pop_id_o   (slv_r_id_o)
`ifdef AXI_ID_REMAP_ERR_EN
    ,
    .pop_free_o (r_pop_free)
`endif
  );

`ifdef AXI_ID_REMAP_ERR_EN
  // Any response beat aimed at a free entry is flagged, last or not.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_o <= 1'b0;
    else if ((b_hs & b_pop_free) | (r_hs & r_pop_free)) err_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_axi_id_remap.sv
module tb_axi_id_remap;

  localparam int SW   = 4;
  localparam int MW   = 2;
  localparam int NU   = 4;
  localparam int MAXT = 4;

  logic          clk_i, rst_i;
  logic [SW-1:0] slv_aw_id;   logic [63:0] slv_aw_pld;  logic slv_aw_valid;  logic slv_aw_ready_o;
  logic [MW-1:0] mst_aw_id_o; logic [63:0] mst_aw_pld_o; logic mst_aw_valid_o; logic mst_aw_ready;
  logic [MW-1:0] mst_b_id;    logic [1:0]  mst_b_pld;   logic mst_b_valid;   logic mst_b_ready_o;
  logic [SW-1:0] slv_b_id_o;  logic [1:0]  slv_b_pld_o; logic slv_b_valid_o; logic slv_b_ready;
  logic [SW-1:0] slv_ar_id;   logic [63:0] slv_ar_pld;  logic slv_ar_valid;  logic slv_ar_ready_o;
  logic [MW-1:0] mst_ar_id_o; logic [63:0] mst_ar_pld_o; logic mst_ar_valid_o; logic mst_ar_ready;
  logic [MW-1:0] mst_r_id;    logic [34:0] mst_r_pld;   logic mst_r_last, mst_r_valid; logic mst_r_ready_o;
  logic [SW-1:0] slv_r_id_o;  logic [34:0] slv_r_pld_o; logic slv_r_last_o, slv_r_valid_o; logic slv_r_ready;
`ifdef AXI_ID_REMAP_ERR_EN
  logic err_o;
`endif

  axi_id_remap #(
    .SlvIdWidth(SW), .MaxUniqIds(NU), .MaxTxnsPerId(MAXT),
    .AwPldWidth(64), .ArPldWidth(64), .BPldWidth(2), .RPldWidth(35)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_aw_id_i(slv_aw_id), .slv_aw_pld_i(slv_aw_pld), .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready_o),
    .mst_aw_id_o(mst_aw_id_o), .mst_aw_pld_o(mst_aw_pld_o), .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready),
    .mst_b_id_i(mst_b_id), .mst_b_pld_i(mst_b_pld), .mst_b_valid_i(mst_b_valid), .mst_b_ready_o(mst_b_ready_o),
    .slv_b_id_o(slv_b_id_o), .slv_b_pld_o(slv_b_pld_o), .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready),
    .slv_ar_id_i(slv_ar_id), .slv_ar_pld_i(slv_ar_pld), .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready_o),
    .mst_ar_id_o(mst_ar_id_o), .mst_ar_pld_o(mst_ar_pld_o), .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready),
    .mst_r_id_i(mst_r_id), .mst_r_pld_i(mst_r_pld), .mst_r_last_i(mst_r_last), .mst_r_valid_i(mst_r_valid), .mst_r_ready_o(mst_r_ready_o),
    .slv_r_id_o(slv_r_id_o), .slv_r_pld_o(slv_r_pld_o), .slv_r_last_o(slv_r_last_o), .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready)
`ifdef AXI_ID_REMAP_ERR_EN
    , .err_o(err_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: per direction, outstanding count and wide id per narrow id.
  int            w_cnt [NU];
  int            r_cnt [NU];
  logic [SW-1:0] w_sid [NU];
  logic [SW-1:0] r_sid [NU];
  bit            err_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NU; i++) begin
      w_cnt[i] = 0; r_cnt[i] = 0; w_sid[i] = '0; r_sid[i] = '0;
    end
    err_exp = 1'b0;
  endtask

  // Same wide id reuses its narrow id; otherwise the lowest idle narrow id.
  function automatic int pick(input bit rd, input logic [SW-1:0] id, output bit ok);
    int free_q[$];
    int c;
    for (int i = 0; i < NU; i++) begin
      c = rd ? r_cnt[i] : w_cnt[i];
      if (c > 0 && (rd ? r_sid[i] : w_sid[i]) == id) begin
        ok = (c < MAXT);
        return i;
      end
      if (c == 0) free_q.push_back(i);
    end
    ok = (free_q.size() > 0);
    return ok ? free_q[0] : 0;
  endfunction

  // Called just after a falling edge with inputs applied; checks the
  // combinational outputs, advances the model and returns at the next
  // falling edge.
  task automatic step();
    bit aw_ok, ar_ok;
    int aw_i, ar_i;
    bit aw_hs, ar_hs, b_hs, r_hs;
    #1;
`ifdef AXI_ID_REMAP_ERR_EN
    check("err", {63'd0, err_o}, {63'd0, err_exp});
`endif
    aw_i = pick(1'b0, slv_aw_id, aw_ok);
    ar_i = pick(1'b1, slv_ar_id, ar_ok);
    check("aw_valid", {63'd0, mst_aw_valid_o}, {63'd0, slv_aw_valid & aw_ok});
    check("aw_ready", {63'd0, slv_aw_ready_o}, {63'd0, mst_aw_ready & aw_ok});
    if (slv_aw_valid && aw_ok) begin
      check("aw_id", {62'd0, mst_aw_id_o}, 64'(aw_i));
      check("aw_pld", mst_aw_pld_o, slv_aw_pld);
    end
    check("ar_valid", {63'd0, mst_ar_valid_o}, {63'd0, slv_ar_valid & ar_ok});
    check("ar_ready", {63'd0, slv_ar_ready_o}, {63'd0, mst_ar_ready & ar_ok});
    if (slv_ar_valid && ar_ok) begin
      check("ar_id", {62'd0, mst_ar_id_o}, 64'(ar_i));
      check("ar_pld", mst_ar_pld_o, slv_ar_pld);
    end
    check("b_valid", {63'd0, slv_b_valid_o}, {63'd0, mst_b_valid});
    check("b_ready", {63'd0, mst_b_ready_o}, {63'd0, slv_b_ready});
    if (mst_b_valid && w_cnt[mst_b_id] > 0) begin
      check("b_id", {60'd0, slv_b_id_o}, {60'd0, w_sid[mst_b_id]});
      check("b_pld", {62'd0, slv_b_pld_o}, {62'd0, mst_b_pld});
    end
    check("r_valid", {63'd0, slv_r_valid_o}, {63'd0, mst_r_valid});
    check("r_ready", {63'd0, mst_r_ready_o}, {63'd0, slv_r_ready});
    if (mst_r_valid && r_cnt[mst_r_id] > 0) begin
      check("r_id", {60'd0, slv_r_id_o}, {60'd0, r_sid[mst_r_id]});
      check("r_pld", {29'd0, slv_r_pld_o}, {29'd0, mst_r_pld});
      check("r_last", {63'd0, slv_r_last_o}, {63'd0, mst_r_last});
    end
    aw_hs = slv_aw_valid && aw_ok && mst_aw_ready;
    ar_hs = slv_ar_valid && ar_ok && mst_ar_ready;
    b_hs  = mst_b_valid && slv_b_ready;
    r_hs  = mst_r_valid && slv_r_ready;
    // Responses first: they see the counts before this cycle's requests.
    if (b_hs) begin
      if (w_cnt[mst_b_id] > 0) w_cnt[mst_b_id]--;
      else err_exp = 1'b1;
    end
    if (r_hs) begin
      if (r_cnt[mst_r_id] == 0) err_exp = 1'b1;
      else if (mst_r_last) r_cnt[mst_r_id]--;
    end
    if (aw_hs) begin w_sid[aw_i] = slv_aw_id; w_cnt[aw_i]++; end
    if (ar_hs) begin r_sid[ar_i] = slv_ar_id; r_cnt[ar_i]++; end
    @(negedge clk_i);
  endtask

  task automatic idle();
    slv_aw_valid = 0; slv_ar_valid = 0; mst_b_valid = 0; mst_r_valid = 0;
    mst_aw_ready = 1; mst_ar_ready = 1; slv_b_ready = 1; slv_r_ready = 1;
    mst_r_last = 0;
  endtask

  task automatic rand_pld();
    slv_aw_pld = {$urandom, $urandom};
    slv_ar_pld = {$urandom, $urandom};
    mst_b_pld  = 2'($urandom);
    mst_r_pld  = 35'({$urandom, $urandom});
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < NU; i++) begin
      while (w_cnt[i] > 0) begin
        mst_b_valid = 1; mst_b_id = MW'(i); rand_pld(); step();
      end
      mst_b_valid = 0;
      while (r_cnt[i] > 0) begin
        mst_r_valid = 1; mst_r_id = MW'(i); mst_r_last = 1; rand_pld(); step();
      end
      mst_r_valid = 0; mst_r_last = 0;
    end
  endtask

  initial begin
    int busy_q[$];
    slv_aw_id = '0; slv_ar_id = '0; mst_b_id = '0; mst_r_id = '0;
    idle(); rand_pld(); model_reset();
    rst_i = 1;
    slv_aw_valid = 1; slv_ar_valid = 1; mst_b_valid = 1; mst_r_valid = 1;
    @(negedge clk_i); @(negedge clk_i);
    check("rst_aw_valid", {63'd0, mst_aw_valid_o}, 64'd0);
    check("rst_aw_ready", {63'd0, slv_aw_ready_o}, 64'd0);
    check("rst_b_valid",  {63'd0, slv_b_valid_o},  64'd0);
    check("rst_r_ready",  {63'd0, mst_r_ready_o},  64'd0);
    idle();
    rst_i = 0;
    @(negedge clk_i);

    // Single write: id 0x9 maps to 0, response restores 0x9.
    slv_aw_valid = 1; slv_aw_id = 4'h9;
    #1; check("t1_aw_id", {62'd0, mst_aw_id_o}, 64'd0);
    check("t1_aw_hs", {63'd0, slv_aw_ready_o & mst_aw_valid_o}, 64'd1);
    step();
    slv_aw_valid = 0; mst_b_valid = 1; mst_b_id = 0;
    #1; check("t1_b_id", {60'd0, slv_b_id_o}, 64'h9);
    step();
    mst_b_valid = 0; slv_aw_valid = 1; slv_aw_id = 4'hA;
    #1; check("t1_freed", {62'd0, mst_aw_id_o}, 64'd0);
    step();
    drain();

    // Same-id reuse up to the per-entry limit.
    slv_aw_valid = 1; slv_aw_id = 4'h3;
    for (int k = 0; k < 4; k++) begin
      #1; check("t2_idx", {62'd0, mst_aw_id_o}, 64'd0);
      step();
    end
    #1; check("t2_stall", {63'd0, slv_aw_ready_o}, 64'd0);
    step();
    mst_b_valid = 1; mst_b_id = 0;
    #1; check("t2_stall_pop", {63'd0, slv_aw_ready_o}, 64'd0);
    step();
    mst_b_valid = 0;
    #1; check("t2_accept", {63'd0, slv_aw_ready_o}, 64'd1);
    check("t2_accept_idx", {62'd0, mst_aw_id_o}, 64'd0);
    step();
    drain();

    // Read table full, then a freed entry is reused.
    slv_ar_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      slv_ar_id = SW'(k);
      #1; check("t3_idx", {62'd0, mst_ar_id_o}, 64'(k - 1));
      step();
    end
    slv_ar_id = 4'h5;
    #1; check("t3_full", {63'd0, slv_ar_ready_o}, 64'd0);
    step();
    mst_r_valid = 1; mst_r_id = 2; mst_r_last = 1;
    step();
    mst_r_valid = 0; mst_r_last = 0;
    #1; check("t3_reuse_rdy", {63'd0, slv_ar_ready_o}, 64'd1);
    check("t3_reuse_idx", {62'd0, mst_ar_id_o}, 64'd2);
    step();
    slv_ar_valid = 0;

    // Four-beat burst on index 1 (stored id 0x2).
    for (int b = 0; b < 4; b++) begin
      mst_r_valid = 1; mst_r_id = 1; mst_r_last = (b == 3); rand_pld();
      #1; check("t4_beat_id", {60'd0, slv_r_id_o}, 64'h2);
      step();
    end
    mst_r_valid = 0; mst_r_last = 0;
    slv_ar_valid = 1; slv_ar_id = 4'h6;
    #1; check("t4_freed", {62'd0, mst_ar_id_o}, 64'd1);
    step();
    drain();

    // Push and final pop on the same entry in one cycle keep it busy.
    slv_aw_valid = 1; slv_aw_id = 4'h7;
    step();
    mst_b_valid = 1; mst_b_id = 0;
    step();
    mst_b_valid = 0; slv_aw_id = 4'h8;
    #1; check("t5_still_busy", {62'd0, mst_aw_id_o}, 64'd1);
    step();
    drain();

`ifdef AXI_ID_REMAP_ERR_EN
    mst_b_valid = 1; mst_b_id = 3;
    step();
    mst_b_valid = 0;
    #1; check("t6_err_set", {63'd0, err_o}, 64'd1);
    step();
    slv_aw_valid = 1;
    for (int k = 0; k < 4; k++) begin
      slv_aw_id = SW'(k + 8);
      #1; check("t6_alloc", {62'd0, mst_aw_id_o}, 64'(k));
      step();
    end
    slv_aw_valid = 0;
    #1; check("t6_err_sticky", {63'd0, err_o}, 64'd1);
    step();
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rand_pld();
      slv_aw_valid = 1'($urandom); slv_aw_id = SW'($urandom_range(0, 7));
      slv_ar_valid = 1'($urandom); slv_ar_id = SW'($urandom_range(0, 7));
      mst_aw_ready = ($urandom_range(0, 3) != 0);
      mst_ar_ready = ($urandom_range(0, 3) != 0);
      slv_b_ready  = 1'($urandom);
      slv_r_ready  = 1'($urandom);
      busy_q.delete();
      for (int i = 0; i < NU; i++) if (w_cnt[i] > 0) busy_q.push_back(i);
      mst_b_valid = (busy_q.size() > 0) && ($urandom_range(0, 2) != 0);
      mst_b_id = (busy_q.size() > 0) ? MW'(busy_q[$urandom_range(0, busy_q.size() - 1)]) : '0;
      busy_q.delete();
      for (int i = 0; i < NU; i++) if (r_cnt[i] > 0) busy_q.push_back(i);
      mst_r_valid = (busy_q.size() > 0) && ($urandom_range(0, 2) != 0);
      mst_r_id = (busy_q.size() > 0) ? MW'(busy_q[$urandom_range(0, busy_q.size() - 1)]) : '0;
      mst_r_last = 1'($urandom);
      step();
    end

    // Reset mid-traffic: handshakes vanish at once, tables empty afterwards.
    slv_aw_valid = 1; slv_ar_valid = 1; mst_aw_ready = 1; mst_ar_ready = 1;
    #2; rst_i = 1;
    #1;
    check("rst2_aw_valid", {63'd0, mst_aw_valid_o}, 64'd0);
    check("rst2_ar_ready", {63'd0, slv_ar_ready_o}, 64'd0);
    check("rst2_b_ready",  {63'd0, mst_b_ready_o},  64'd0);
    check("rst2_r_valid",  {63'd0, slv_r_valid_o},  64'd0);
`ifdef AXI_ID_REMAP_ERR_EN
    check("rst2_err", {63'd0, err_o}, 64'd0);
`endif
    model_reset();
    @(negedge clk_i);
    idle(); rst_i = 0;
    @(negedge clk_i);
    slv_aw_valid = 1; slv_aw_id = 4'hF; slv_ar_valid = 1; slv_ar_id = 4'hE;
    #1; check("rst2_aw_idx", {62'd0, mst_aw_id_o}, 64'd0);
    check("rst2_ar_idx", {62'd0, mst_ar_id_o}, 64'd0);
    step();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
